// File: rtl/atr_sequencer16_pkg.sv
// Shared definitions for the ATR sequencer: FSM state encodings, register
// word addresses, ATR table index constants and the byte-lane merge helper.
// Package name: atr_seq_pkg (imported by every file of the block).
package atr_seq_pkg;

    localparam int unsigned REG_W = 16;
    localparam int unsigned ADR_W = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned ATR_W = 4;

    // Per-direction FSM state encodings
    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_ON_WAIT  = 2'd1;
    localparam logic [1:0] ST_ON       = 2'd2;
    localparam logic [1:0] ST_OFF_WAIT = 2'd3;

    // Register word addresses (adr_i[3:1])
    localparam logic [IDX_W-1:0] REG_TX_ON_DLY  = 3'd0;
    localparam logic [IDX_W-1:0] REG_TX_OFF_DLY = 3'd1;
    localparam logic [IDX_W-1:0] REG_RX_ON_DLY  = 3'd2;
    localparam logic [IDX_W-1:0] REG_RX_OFF_DLY = 3'd3;
    localparam logic [IDX_W-1:0] REG_STATUS     = 3'd4;

    // ATR table index constants; bit 2 marks a pending transition
    localparam logic [ATR_W-1:0] ATR_IDLE        = 4'd0;
    localparam logic [ATR_W-1:0] ATR_TX          = 4'd1;
    localparam logic [ATR_W-1:0] ATR_RX          = 4'd2;
    localparam logic [ATR_W-1:0] ATR_FULL_DUPLEX = 4'd3;
    localparam int unsigned      ATR_PENDING_BIT = 2;

    // Read-only status word layout
    typedef struct packed {
        logic [11:0] rsvd;
        logic        rx_wait;
        logic        tx_wait;
        logic        rx_active;
        logic        tx_active;
    } status_t;

    // Apply a byte-lane-qualified write to a 16-bit register value
    function automatic logic [REG_W-1:0] merge_lanes(
        input logic [REG_W-1:0] cur,
        input logic [REG_W-1:0] wdat,
        input logic [SEL_W-1:0] sel
    );
        logic [REG_W-1:0] res;
        res = cur;
        if (sel[0]) res[7:0]  = wdat[7:0];
        if (sel[1]) res[15:8] = wdat[15:8];
        return res;
    endfunction

endpackage

// File: rtl/atr_sequencer16_if.sv
// Wishbone slave bus bundle for the ATR sequencer register file.
// Signals: adr_i/sel_i/dat_i/we_i/stb_i/cyc_i (master -> slave),
//          dat_o/ack_o (slave -> master).
interface atr_sequencer16_if;
    import atr_seq_pkg::*;

    logic [ADR_W-1:0] adr_i;
    logic [SEL_W-1:0] sel_i;
    logic [REG_W-1:0] dat_i;
    logic [REG_W-1:0] dat_o;
    logic             we_i;
    logic             stb_i;
    logic             cyc_i;
    logic             ack_o;

    modport slave (
        input  adr_i, sel_i, dat_i, we_i, stb_i, cyc_i,
        output dat_o, ack_o
    );

    modport master (
        output adr_i, sel_i, dat_i, we_i, stb_i, cyc_i,
        input  dat_o, ack_o
    );

endinterface

// File: rtl/atr_delay_chan.sv
// One direction of the ATR sequencer: OFF/ON_WAIT/ON/OFF_WAIT FSM with a
// CW-bit delay counter and abort on reversal of the run flag.
// Ports: clk, rst (sync, active-high), run, on_dly, off_dly in;
//        active_c, wait_c out -- flags of the NEXT state, registered by the
//        parent so its outputs line up with the state register.
module atr_delay_chan
    import atr_seq_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] on_dly,
    input  logic [CW-1:0] off_dly,
    output logic          active_c,
    output logic          wait_c
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; delay inputs are only sampled on entry to a wait state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                if (run) begin
                    if (on_dly == '0) begin
                        state_nxt = ST_ON;
                    end else begin
                        state_nxt = ST_ON_WAIT;
                        cnt_nxt   = on_dly - CW'(1);
                    end
                end
            end
            ST_ON_WAIT: begin
                if (!run) begin
                    state_nxt = ST_OFF;
                end else if (cnt == '0) begin
                    state_nxt = ST_ON;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_ON: begin
                if (!run) begin
                    if (off_dly == '0) begin
                        state_nxt = ST_OFF;
                    end else begin
                        state_nxt = ST_OFF_WAIT;
                        cnt_nxt   = off_dly - CW'(1);
                    end
                end
            end
            ST_OFF_WAIT: begin
                if (run) begin
                    state_nxt = ST_ON;
                end else if (cnt == '0) begin
                    state_nxt = ST_OFF;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign active_c = (state_nxt == ST_ON)      || (state_nxt == ST_OFF_WAIT);
    assign wait_c   = (state_nxt == ST_ON_WAIT) || (state_nxt == ST_OFF_WAIT);

endmodule

// File: rtl/atr_sequencer16.sv
// Programmable-delay ATR sequencer: turns raw run_tx/run_rx strobes into the
// 4-bit ATR table index with independent on/off delays per direction.
// Ports: clk_i, rst_i (sync, active-high); wb (Wishbone slave, delay regs);
//        run_rx, run_tx in; atr_state, tx_active, rx_active out (registered).
// Build option: ATR_SEQ_READBACK_EN enables register/STATUS readback on dat_o;
//        without it dat_o is tied to 0 and the delay registers are write-only.
module atr_sequencer16
    import atr_seq_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    atr_sequencer16_if.slave wb,
    input  logic             run_rx,
    input  logic             run_tx,
    output logic [ATR_W-1:0] atr_state,
    output logic             tx_active,
    output logic             rx_active
);

    logic [REG_W-1:0] tx_on_dly;
    logic [REG_W-1:0] tx_off_dly;
    logic [REG_W-1:0] rx_on_dly;
    logic [REG_W-1:0] rx_off_dly;
    logic             ack_q;
    logic             strobe_c;
    logic             wr_c;
    logic [IDX_W-1:0] reg_idx_c;
    logic             tx_active_c;
    logic             tx_wait_c;
    logic             rx_active_c;
    logic             rx_wait_c;
    logic [ATR_W-1:0] atr_nxt_c;
    logic             unused_adr;

    // A new strobe is accepted only when no ack is outstanding
    assign strobe_c  = wb.stb_i & wb.cyc_i & ~ack_q;
    assign wr_c      = strobe_c & wb.we_i;
    assign reg_idx_c = wb.adr_i[3:1];
    assign unused_adr = &{1'b0, wb.adr_i[5:4], wb.adr_i[0]};

    // Ack generation and delay register file
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            tx_on_dly  <= '0;
            tx_off_dly <= '0;
            rx_on_dly  <= '0;
            rx_off_dly <= '0;
        end else begin
            ack_q <= strobe_c;
            if (wr_c) begin
                case (reg_idx_c)
                    REG_TX_ON_DLY:  tx_on_dly  <= merge_lanes(tx_on_dly,  wb.dat_i, wb.sel_i);
                    REG_TX_OFF_DLY: tx_off_dly <= merge_lanes(tx_off_dly, wb.dat_i, wb.sel_i);
                    REG_RX_ON_DLY:  rx_on_dly  <= merge_lanes(rx_on_dly,  wb.dat_i, wb.sel_i);
                    REG_RX_OFF_DLY: rx_off_dly <= merge_lanes(rx_off_dly, wb.dat_i, wb.sel_i);
                    default: ;
                endcase
            end
        end
    end

    assign wb.ack_o = ack_q;

    atr_delay_chan #(.CW(CW)) u_tx_chan (
        .clk      (clk_i),
        .rst      (rst_i),
        .run      (run_tx),
        .on_dly   (CW'(tx_on_dly)),
        .off_dly  (CW'(tx_off_dly)),
        .active_c (tx_active_c),
        .wait_c   (tx_wait_c)
    );

    atr_delay_chan #(.CW(CW)) u_rx_chan (
        .clk      (clk_i),
        .rst      (rst_i),
        .run      (run_rx),
        .on_dly   (CW'(rx_on_dly)),
        .off_dly  (CW'(rx_off_dly)),
        .active_c (rx_active_c),
        .wait_c   (rx_wait_c)
    );

    // ATR index from the channels' next-state flags so it tracks the FSMs
    always_comb begin
        atr_nxt_c = ATR_IDLE;
        if (tx_active_c) atr_nxt_c = atr_nxt_c | ATR_TX;
        if (rx_active_c) atr_nxt_c = atr_nxt_c | ATR_RX;
        atr_nxt_c[ATR_PENDING_BIT] = tx_wait_c | rx_wait_c;
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            atr_state <= ATR_IDLE;
            tx_active <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            atr_state <= atr_nxt_c;
            tx_active <= tx_active_c;
            rx_active <= rx_active_c;
        end
    end

`ifdef ATR_SEQ_READBACK_EN
    logic             tx_wait;
    logic             rx_wait;
    logic [REG_W-1:0] dat_q;
    logic [REG_W-1:0] rd_data_c;
    status_t          status_c;

    always_comb begin
        status_c           = '0;
        status_c.rx_wait   = rx_wait;
        status_c.tx_wait   = tx_wait;
        status_c.rx_active = rx_active;
        status_c.tx_active = tx_active;
    end

    // Read mux; unmapped words read as zero
    always_comb begin
        rd_data_c = '0;
        case (reg_idx_c)
            REG_TX_ON_DLY:  rd_data_c = tx_on_dly;
            REG_TX_OFF_DLY: rd_data_c = tx_off_dly;
            REG_RX_ON_DLY:  rd_data_c = rx_on_dly;
            REG_RX_OFF_DLY: rd_data_c = rx_off_dly;
            REG_STATUS:     rd_data_c = status_c;
            default:        rd_data_c = '0;
        endcase
    end

    // Wait flags for STATUS and read data captured on the strobe edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wait <= 1'b0;
            rx_wait <= 1'b0;
            dat_q   <= '0;
        end else begin
            tx_wait <= tx_wait_c;
            rx_wait <= rx_wait_c;
            if (strobe_c) dat_q <= rd_data_c;
        end
    end

    assign wb.dat_o = dat_q;
`else
    assign wb.dat_o = '0;
`endif

endmodule

// File: tb/tb_atr_sequencer16.sv
// Directed self-checking bench for atr_sequencer16.
module tb_atr_sequencer16;
    import atr_seq_pkg::*;

    logic       clk;
    logic       rst_i;
    logic       run_tx;
    logic       run_rx;
    logic [3:0] atr_state;
    logic       tx_active;
    logic       rx_active;
    int         errors;
    int         checks;

    atr_sequencer16_if wb ();

    atr_sequencer16 #(.CW(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .wb        (wb),
        .run_rx    (run_rx),
        .run_tx    (run_tx),
        .atr_state (atr_state),
        .tx_active (tx_active),
        .rx_active (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single Wishbone write; returns at the negedge after the strobe edge
    task automatic wb_write(input logic [2:0] idx, input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        wb.adr_i = {2'b00, idx, 1'b0};
        wb.sel_i = sel;
        wb.dat_i = data;
        wb.we_i  = 1'b1;
        wb.stb_i = 1'b1;
        wb.cyc_i = 1'b1;
        @(negedge clk);
        wb.we_i  = 1'b0;
        wb.stb_i = 1'b0;
        wb.cyc_i = 1'b0;
    endtask

    // Single Wishbone read; data and ack sampled while ack is expected high
    task automatic wb_read(input logic [2:0] idx, output logic [15:0] data, output logic ack);
        @(negedge clk);
        wb.adr_i = {2'b00, idx, 1'b0};
        wb.sel_i = 2'b11;
        wb.we_i  = 1'b0;
        wb.stb_i = 1'b1;
        wb.cyc_i = 1'b1;
        @(negedge clk);
        data = wb.dat_o;
        ack  = wb.ack_o;
        wb.stb_i = 1'b0;
        wb.cyc_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE || tx_active !== 1'b0 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: atr=%0d tx=%b rx=%b, need 0 0 0", atr_state, tx_active, rx_active);
        end
        checks++;
        if (wb.ack_o !== 1'b0 || wb.dat_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: ack=%b dat=%h, need 0 0000", wb.ack_o, wb.dat_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        // Zero delay: pass-through on the first sampling edge
        run_tx = 1'b1;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL zero_dly_on: atr=%0d tx=%b, need 1 1", atr_state, tx_active);
        end
        run_tx = 1'b0;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL zero_dly_off: atr=%0d tx=%b, need 0 0", atr_state, tx_active);
        end
    endtask

    task automatic test_tx_on_dly();
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd5);
        run_tx = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (atr_state !== 4'd4 || tx_active !== 1'b0) begin
                errors++;
                $display("FAIL tx_on_wait[%0d]: atr=%0d tx=%b, need 4 0", i, atr_state, tx_active);
            end
        end
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL tx_on_done: atr=%0d tx=%b, need 1 1", atr_state, tx_active);
        end
        run_tx = 1'b0;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE) begin
            errors++;
            $display("FAIL tx_on_drop: atr=%0d, need 0", atr_state);
        end
    endtask

    task automatic test_on_abort();
        wb_write(REG_RX_ON_DLY, 2'b11, 16'd10);
        run_rx = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (atr_state !== 4'd4 || rx_active !== 1'b0) begin
                errors++;
                $display("FAIL on_abort_wait: atr=%0d rx=%b, need 4 0", atr_state, rx_active);
            end
        end
        run_rx = 1'b0;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE) begin
            errors++;
            $display("FAIL on_abort_idle: atr=%0d, need 0", atr_state);
        end
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (rx_active !== 1'b0 || atr_state !== ATR_IDLE) begin
                errors++;
                $display("FAIL on_abort_stay: atr=%0d rx=%b, need 0 0", atr_state, rx_active);
            end
        end
    endtask

    task automatic test_off_abort();
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd0);
        wb_write(REG_TX_OFF_DLY, 2'b11, 16'd8);
        run_tx = 1'b1;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX) begin
            errors++;
            $display("FAIL off_abort_on: atr=%0d, need 1", atr_state);
        end
        run_tx = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (atr_state !== 4'd5 || tx_active !== 1'b1) begin
                errors++;
                $display("FAIL off_abort_wait: atr=%0d tx=%b, need 5 1", atr_state, tx_active);
            end
        end
        run_tx = 1'b1;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL off_abort_back: atr=%0d tx=%b, need 1 1", atr_state, tx_active);
        end
    endtask

    task automatic test_tx_off_dly();
        // TX_OFF_DLY = 8 still loaded, run_tx high on entry
        run_tx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (atr_state !== 4'd5 || tx_active !== 1'b1) begin
                errors++;
                $display("FAIL tx_off_wait[%0d]: atr=%0d tx=%b, need 5 1", i, atr_state, tx_active);
            end
        end
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL tx_off_done: atr=%0d tx=%b, need 0 0", atr_state, tx_active);
        end
    endtask

    task automatic test_full_duplex();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd4, 4'd4, 4'd5, 4'd5, ATR_FULL_DUPLEX};
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd2);
        wb_write(REG_RX_ON_DLY, 2'b11, 16'd4);
        run_tx = 1'b1;
        run_rx = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (atr_state !== exp_seq[i]) begin
                errors++;
                $display("FAIL full_duplex[%0d]: atr=%0d, need %0d", i, atr_state, exp_seq[i]);
            end
        end
        run_rx = 1'b0;
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL fd_rx_drop: atr=%0d rx=%b, need 1 0", atr_state, rx_active);
        end
        run_tx = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE) begin
            errors++;
            $display("FAIL fd_tx_drop: atr=%0d, need 0", atr_state);
        end
    endtask

    task automatic test_write_during_wait();
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd3);
        run_tx = 1'b1;
        @(negedge clk);
        checks++;
        if (atr_state !== 4'd4) begin
            errors++;
            $display("FAIL wdw_start: atr=%0d, need 4", atr_state);
        end
        // Write lands on edge k+2; running count must not reload
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd20);
        checks++;
        if (atr_state !== 4'd4) begin
            errors++;
            $display("FAIL wdw_mid: atr=%0d, need 4", atr_state);
        end
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_TX || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL wdw_done: atr=%0d tx=%b, need 1 1", atr_state, tx_active);
        end
        run_tx = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE) begin
            errors++;
            $display("FAIL wdw_off: atr=%0d, need 0", atr_state);
        end
    endtask

    task automatic test_back_to_back_ack();
        @(negedge clk);
        wb.adr_i = 6'd0;
        wb.we_i  = 1'b0;
        wb.stb_i = 1'b1;
        wb.cyc_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (wb.ack_o !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: ack=%b, need %b", i, wb.ack_o, (i % 2) == 0);
            end
        end
        wb.stb_i = 1'b0;
        wb.cyc_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_status_and_reset();
        logic [15:0] rd;
        logic        ack;
        // TX_ON_DLY = 20 now; shorten it and keep TX_OFF_DLY = 8
        wb_write(REG_TX_ON_DLY, 2'b11, 16'd0);
        run_tx = 1'b1;
        @(negedge clk);
        run_tx = 1'b0;
        @(negedge clk);
        checks++;
        if (atr_state !== 4'd5) begin
            errors++;
            $display("FAIL rst_pre_wait: atr=%0d, need 5", atr_state);
        end
`ifdef ATR_SEQ_READBACK_EN
        wb_read(REG_STATUS, rd, ack);
        checks++;
        if (rd !== 16'h0005 || ack !== 1'b1) begin
            errors++;
            $display("FAIL status_off_wait: dat=%h ack=%b, need 0005 1", rd, ack);
        end
`else
        wb_read(REG_TX_OFF_DLY, rd, ack);
        checks++;
        if (rd !== 16'h0000 || ack !== 1'b1) begin
            errors++;
            $display("FAIL no_readback: dat=%h ack=%b, need 0000 1", rd, ack);
        end
`endif
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (atr_state !== 4'd0 || tx_active !== 1'b0 || rx_active !== 1'b0 ||
            wb.ack_o !== 1'b0 || wb.dat_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_wait: atr=%0d tx=%b rx=%b ack=%b dat=%h, need all 0",
                     atr_state, tx_active, rx_active, wb.ack_o, wb.dat_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        // Delay registers cleared: zero-delay pass-through again
        run_tx = 1'b1;
        @(negedge clk);
        run_tx = 1'b0;
        checks++;
        if (atr_state !== ATR_TX) begin
            errors++;
            $display("FAIL reset_regs_clear: atr=%0d, need 1", atr_state);
        end
        @(negedge clk);
        checks++;
        if (atr_state !== ATR_IDLE) begin
            errors++;
            $display("FAIL reset_regs_off: atr=%0d, need 0", atr_state);
        end
    endtask

`ifdef ATR_SEQ_READBACK_EN
    task automatic test_readback();
        logic [15:0] rd;
        logic        ack;
        wb_write(REG_TX_OFF_DLY, 2'b01, 16'hFFA5);
        wb_read(REG_TX_OFF_DLY, rd, ack);
        checks++;
        if (rd !== 16'h00A5 || ack !== 1'b1) begin
            errors++;
            $display("FAIL rb_low_lane: dat=%h ack=%b, need 00a5 1", rd, ack);
        end
        wb_write(REG_TX_OFF_DLY, 2'b10, 16'h3C11);
        wb_read(REG_TX_OFF_DLY, rd, ack);
        checks++;
        if (rd !== 16'h3CA5) begin
            errors++;
            $display("FAIL rb_high_lane: dat=%h, need 3ca5", rd);
        end
        wb_write(REG_STATUS, 2'b11, 16'hFFFF);
        wb_read(REG_STATUS, rd, ack);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL rb_status_ro: dat=%h, need 0000", rd);
        end
        wb_write(3'd5, 2'b11, 16'hBEEF);
        wb_read(3'd5, rd, ack);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL rb_unmapped: dat=%h, need 0000", rd);
        end
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        rst_i    = 1'b1;
        run_tx   = 1'b0;
        run_rx   = 1'b0;
        wb.adr_i = '0;
        wb.sel_i = '0;
        wb.dat_i = '0;
        wb.we_i  = 1'b0;
        wb.stb_i = 1'b0;
        wb.cyc_i = 1'b0;

        test_reset();
        test_tx_on_dly();
        test_on_abort();
        test_off_abort();
        test_tx_off_dly();
        test_full_duplex();
        test_write_during_wait();
        test_back_to_back_ack();
        test_status_and_reset();
`ifdef ATR_SEQ_READBACK_EN
        test_readback();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atr_sequencer16.md
# atr_sequencer16

Programmable-delay sequencer that drives the 4-bit state index of the 16-entry ATR control-line table from the raw `run_tx` / `run_rx` strobes. Each direction gets independent turn-on and turn-off delays, so daughterboard switches, PAs and LNAs settle before or after the DSP runs. Each direction's state machine supports abort on reversal. The block has a 16-bit Wishbone slave for its delay registers and sits between the DSP run flags and the ATR table lookup.

## Interface
Parameters:
- `CW`, default 16: delay counter width; delays are 0..2^CW-1 cycles.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `adr_i`, in, 6: Wishbone byte address; `adr_i[3:1]` selects the 16-bit register.
- `sel_i`, in, 2: byte lane selects.
- `dat_i`, in, 16: write data.
- `dat_o`, out, 16: read data.
- `we_i`, `stb_i`, `cyc_i`, in, 1 each: Wishbone controls.
- `ack_o`, out, 1: Wishbone acknowledge.
- `run_rx`, `run_tx`, in, 1 each: raw DSP run flags, synchronous to `clk_i`.
- `atr_state`, out, 4: ATR table index.
- `tx_active`, `rx_active`, out, 1 each: delayed (effective) enables.

## Operation
- Registers are 16 bits, reset value 0, and honour byte lanes:
  - 0: TX_ON_DLY
  - 1: TX_OFF_DLY
  - 2: RX_ON_DLY
  - 3: RX_OFF_DLY
  - 4: STATUS, read-only: `{12'b0, rx_wait, tx_wait, rx_active, tx_active}`. Writes to it are ignored.
  - Addresses 5–7 read as 0 and ignore writes.
- Per-direction FSM, identical for TX and RX, with states OFF, ON_WAIT, ON, OFF_WAIT:
  - OFF: if `run` and ON_DLY == 0, go to ON. If `run` and ON_DLY > 0, go to ON_WAIT with `cnt <= ON_DLY-1`.
  - ON_WAIT: if `!run`, go to OFF (abort, the direction never becomes active). Else if `cnt == 0`, go to ON. Else decrement `cnt`.
  - ON: if `!run` and OFF_DLY == 0, go to OFF. If `!run` and OFF_DLY > 0, go to OFF_WAIT with `cnt <= OFF_DLY-1`.
  - OFF_WAIT: if `run`, go to ON (abort, stays active). Else if `cnt == 0`, go to OFF. Else decrement `cnt`.
- Active and wait flags:
  - `active` = ON or OFF_WAIT.
  - `wait` = ON_WAIT or OFF_WAIT.
- Output index:
  - `atr_state = {1'b0, tx_wait | rx_wait, rx_active, tx_active}`.
  - Entries 0–3 are IDLE, TX, RX and FULL_DUPLEX.
  - Entries 4–7 are the same four combinations while any transition is pending.
- Delay registers are sampled only on entry to a wait state. Writes during a wait do not alter the running count.
- TX and RX are fully independent. Simultaneous changes on both flags are processed in the same cycle.
- Reset, including reset mid-wait:
  - Both FSMs go to OFF and counters to 0.
  - All delay registers go to 0.
  - `atr_state`, `tx_active`, `rx_active`, `ack_o` and `dat_o` are all 0.

## Timing
- With delay D and `run` first sampled high at edge k, `active` rises at edge k+D. D = 0 is therefore a one-register pass-through.
- Turn-off follows the same rule with OFF_DLY.
- `atr_state` and the active outputs are registered and have no combinational path from `run_*`.
- `ack_o <= stb_i & cyc_i & ~ack_o`: a single-cycle ack one cycle after the strobe. Back-to-back strobes are acked on every other cycle.
- Writes take effect on the same edge that sets `ack_o`.
- The maximum delay is 65535 cycles. The counter never wraps, because it saturates at 0 through the FSM exit.

## Configuration
- `ATR_SEQ_READBACK_EN` defined: `dat_o` is registered on the strobe edge, is the selected register or STATUS, and is valid with `ack_o`.
- Not defined: `dat_o` is constant 0 and STATUS is not readable. The state machines are unaffected and the delay registers are write-only.

## Structure
- Shared package `atr_seq_pkg` holds:
  - the FSM state encodings (OFF, ON_WAIT, ON, OFF_WAIT);
  - the register word addresses (0–4);
  - the ATR index constants IDLE, TX, RX, FULL_DUPLEX, and the pending bit position 2.
- Sub-module `atr_delay_chan` contains one FSM plus its `CW`-bit counter. It has inputs `run`, `on_dly` and `off_dly`, and outputs `active` and `wait`. It is instantiated twice, once for TX and once for RX.
- The top level contains the Wishbone decode, the register file, readback and `atr_state` assembly.

## Test plan
- Reset defaults: after reset, pulse `run_tx` high with all delays 0. `tx_active` and `atr_state = 1` must appear on the first edge that samples `run_tx`. Drop `run_tx` and `atr_state` must return to 0 on the next edge.
- TX_ON_DLY: write TX_ON_DLY = 5 and raise `run_tx` at edge k. Required: `atr_state = 4` over edges k..k+4, then `atr_state = 1` at edge k+5.
- Turn-on abort: RX_ON_DLY = 10, raise `run_rx`, then drop it after 3 cycles. `rx_active` never rises, and `atr_state` goes 4 then 0.
- Turn-off abort: TX_OFF_DLY = 8, drop `run_tx`, then re-raise it after 2 cycles. `tx_active` stays 1 throughout, and `atr_state` goes 5 then 1.
- Full duplex: TX_ON_DLY = 2 and RX_ON_DLY = 4, raise both flags at edge k. Required `atr_state` sequence: 4, 4, 5, 5, then 3 from edge k+4.
- Reset and readback: assert `rst_i` mid-OFF_WAIT; all outputs must be 0 on the next edge. With `ATR_SEQ_READBACK_EN`, write 0xA5 to the low byte of TX_OFF_DLY and read back 0x00A5. Read STATUS and check it matches the FSM states.
